sync_delay_sched: RTL



---
 rtl/sync_delay_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sync_delay_sched.sv
// Round-robin scheduler feeding NCH producers into one programmable-depth sync delay line.
// Optional build macro SYNC_DELAY_SCHED_CH0_PRIO_EN gives channel 0 absolute priority.
module sync_delay_sched #(
  parameter int NCH       = 4,
  parameter int W         = 32,
  parameter int DMAX      = 8,
  parameter int DEF_DELAY = 2
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic [NCH-1:0]   srdyi,
  input  logic [NCH*W-1:0] sync_i,
  output logic [NCH-1:0]   sready,
  input  logic [3:0]       delay_cfg,
  input  logic             cfg_load,
  output logic [W-1:0]     sync_o,
  output logic             srdyo,
  output logic [2:0]       chan_o,
  output logic             busy,
  output logic             cfg_rej
);

`ifdef SYNC_DELAY_SCHED_CH0_PRIO_EN
  localparam int unsigned FIRST_RR = 1;
`else
  localparam int unsigned FIRST_RR = 0;
`endif

  logic [NCH-1:0]  hold_v, hold_nxt, acc, gnt_oh;
  logic [W-1:0]    hold_w [NCH];
  logic [2:0]      ptr, gnt;
  logic            gnt_v;
  logic [W-1:0]    gnt_w;
  logic [DMAX-1:0] stg_v, stg_v_nxt;
  logic [2:0]      stg_c [DMAX];
  logic [W-1:0]    stg_w [DMAX];
  logic [3:0]      dly, dly_map;
  logic            tap_v;
  logic [2:0]      tap_c;
  logic [W-1:0]    tap_w;
  logic            cfg_ok;

  assign acc      = srdyi & sready;
  assign hold_nxt = (hold_v & ~gnt_oh) | acc;
  assign cfg_ok   = cfg_load && !busy && (srdyi == '0);

  always_comb begin
    int unsigned c;
    c      = 0;
    gnt_v  = 1'b0;
    gnt    = '0;
    gnt_oh = '0;
    for (int unsigned off = 0; off < NCH; off++) begin
      c = 32'(ptr) + off;
      if (c >= NCH) c = c - NCH;
      for (int unsigned ch = FIRST_RR; ch < NCH; ch++) begin
        if (!gnt_v && ch == c && hold_v[ch]) begin
          gnt_v      = 1'b1;
          gnt        = 3'(ch);
          gnt_oh[ch] = 1'b1;
        end
      end
    end
`ifdef SYNC_DELAY_SCHED_CH0_PRIO_EN
    if (hold_v[0]) begin
      gnt_v     = 1'b1;
      gnt       = '0;
      gnt_oh    = '0;
      gnt_oh[0] = 1'b1;
    end
`endif
  end

  always_comb begin
    gnt_w = '0;
    for (int unsigned ch = 0; ch < NCH; ch++)
      if (gnt_oh[ch]) gnt_w = hold_w[ch];
  end

  // Words leaving stage D are consumed, so a later increase of D cannot resurrect them.
  always_comb begin
    stg_v_nxt    = '0;
    stg_v_nxt[0] = gnt_v;
    for (int unsigned k = 1; k < DMAX; k++)
      stg_v_nxt[k] = stg_v[k-1] && (4'(k) < dly);
    tap_v = 1'b0;
    tap_c = stg_c[0];
    tap_w = stg_w[0];
    for (int unsigned k = 0; k < DMAX; k++) begin
      if (4'(k + 1) == dly) begin
        tap_v = stg_v[k];
        tap_c = stg_c[k];
        tap_w = stg_w[k];
      end
    end
  end

  always_comb begin
    if (delay_cfg == 4'd0)              dly_map = 4'd1;
    else if (delay_cfg > 4'(DMAX))      dly_map = 4'(DMAX);
    else                                dly_map = delay_cfg;
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      hold_v  <= '0;
      sready  <= '1;
      ptr     <= '0;
      stg_v   <= '0;
      dly     <= 4'(DEF_DELAY);
      sync_o  <= '0;
      srdyo   <= 1'b0;
      chan_o  <= '0;
      busy    <= 1'b0;
      cfg_rej <= 1'b0;
    end else begin
      hold_v  <= hold_nxt;
      sready  <= ~hold_nxt;
      stg_v   <= stg_v_nxt;
      busy    <= (|hold_nxt) | (|stg_v_nxt);
      srdyo   <= tap_v;
      cfg_rej <= cfg_load && !cfg_ok;
      if (tap_v) begin
        sync_o <= tap_w;
        chan_o <= tap_c;
      end
      if (cfg_ok) dly <= dly_map;
`ifdef SYNC_DELAY_SCHED_CH0_PRIO_EN
      if (gnt_v && gnt != 3'd0)
`else
      if (gnt_v)
`endif
        ptr <= (gnt == 3'(NCH - 1)) ? '0 : gnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned ch = 0; ch < NCH; ch++)
      if (acc[ch]) hold_w[ch] <= sync_i[ch*W +: W];
    stg_w[0] <= gnt_w;
    stg_c[0] <= gnt;
    for (int unsigned k = 1; k < DMAX; k++) begin
      stg_w[k] <= stg_w[k-1];
      stg_c[k] <= stg_c[k-1];
    end
  end

endmodule
